// File: rtl/fifo_read_prefetch_pkg.sv
// Shared sizing helpers for the FIFO read-side prefetch stage.
package fifo_read_prefetch_pkg;

  localparam int DEFAULT_WIDTH        = 8;
  localparam int DEFAULT_READ_LATENCY = 1;

  // Bits needed to hold a count in 0..max_count (never less than one bit).
  function automatic int count_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  // Bits needed to index an array of `depth` entries (never less than one bit).
  function automatic int index_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_prefetch_buffer.sv
// In-order register buffer with lap-bit pointers and a registered head word/valid.
module fifo_prefetch_buffer
  import fifo_read_prefetch_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = 2,
  parameter int LEVEL_WIDTH = count_width(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [LEVEL_WIDTH-1:0] level
);

  localparam int IW = index_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW:0]      head_ptr, tail_ptr;
  logic             head_valid_q, next_valid;
  logic [WIDTH-1:0] head_data_q, next_data;
  int               count;

  // Pointer MSB is the lap bit; the index wraps at DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [IW:0] advance(input logic [IW:0] p);
    if (p[IW-1:0] == IW'(DEPTH - 1)) return {~p[IW], {IW{1'b0}}};
    return {p[IW], p[IW-1:0] + 1'b1};
  endfunction

  always_comb begin
    if (head_ptr[IW] == tail_ptr[IW])
      count = int'(tail_ptr[IW-1:0]) - int'(head_ptr[IW-1:0]);
    else
      count = DEPTH - int'(head_ptr[IW-1:0]) + int'(tail_ptr[IW-1:0]);
    level = LEVEL_WIDTH'(count);
  end

  // The head word is pre-selected into its own register so the consumer sees flop outputs.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    next_valid = head_valid_q;
    next_data  = head_data_q;
    if (pop && level > LEVEL_WIDTH'(1)) begin
      next_data = mem[advance(head_ptr)];
    end else if (pop || !head_valid_q) begin
      next_valid = push;
      if (push) next_data = push_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_ptr     <= '0;
      tail_ptr     <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      if (push) tail_ptr <= advance(tail_ptr);
      if (pop)  head_ptr <= advance(head_ptr);
      head_valid_q <= next_valid;
      head_data_q  <= next_data;
    end
  end

  // NOTE: storage has no reset; only pointers and the head register define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[tail_ptr[IW-1:0]] <= push_data;
  end

  assign head_valid = head_valid_q;
  assign head_data  = head_data_q;

  no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push && !pop && level == LEVEL_WIDTH'(DEPTH)));
  no_underflow: assert property (@(posedge clock) disable iff (!resetn)
    !(pop && !head_valid_q));

endmodule

// File: rtl/fifo_read_prefetch.sv
// Turns the FIFO controller's raw read port into a registered valid/ready stream via credit-based prefetch.
module fifo_read_prefetch
  import fifo_read_prefetch_pkg::*;
#(
  parameter  int WIDTH        = DEFAULT_WIDTH,
  parameter  int READ_LATENCY = DEFAULT_READ_LATENCY,
  localparam int BUFFER_DEPTH = READ_LATENCY + 1,
  localparam int LEVEL_WIDTH  = count_width(BUFFER_DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  input  logic [WIDTH-1:0]       fifo_read_data,
  output logic                   read_valid,
  input  logic                   read_ready,
  output logic [WIDTH-1:0]       read_data,
  output logic [LEVEL_WIDTH-1:0] level
);

  logic pop;
  logic push;
  int   inflight_count;
  int   credit;

  assign pop = read_valid && read_ready;

  if (READ_LATENCY == 0) begin : g_no_latency
    assign push           = fifo_read_enable;
    assign inflight_count = 0;
  end else begin : g_latency
    logic [READ_LATENCY-1:0] issue_q;

    // One flag per issued read; the flag falling off the end marks its data arriving.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) issue_q <= '0;
      else         issue_q <= (issue_q << 1) | READ_LATENCY'(fifo_read_enable);
    end

    always_comb begin
      inflight_count = 0;
      for (int i = 0; i < READ_LATENCY; i++) inflight_count += int'(issue_q[i]);
    end

    assign push = issue_q[READ_LATENCY-1];
  end

  // Credit counts stored plus requested words, so returned data always has a slot.
  always_comb begin
    credit           = int'(level) + inflight_count - (pop ? 1 : 0);
    fifo_read_enable = !fifo_empty && (credit < BUFFER_DEPTH);
  end

  fifo_prefetch_buffer #(
    .WIDTH      (WIDTH),
    .DEPTH      (BUFFER_DEPTH),
    .LEVEL_WIDTH(LEVEL_WIDTH)
  ) u_buffer (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (fifo_read_data),
    .pop       (pop),
    .head_valid(read_valid),
    .head_data (read_data),
    .level     (level)
  );

endmodule
